// File: rtl/btb_update_sched_pkg.sv
// Shared types for the BTB update scheduler.
//   word_t        : 32-bit machine word (instr_npc, targets)
//   btb_op_t      : kind of BTB write (invalidate, branch update, jump install)
//   btb_upd_t     : one queued BTB update
//   sched_state_t : scheduler FSM state
package btb_update_sched_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      BTB_INVAL  = 2'd0,
      BTB_BRANCH = 2'd1,
      BTB_JUMP   = 2'd2
   } btb_op_t;

   typedef struct packed {
      btb_op_t op;
      word_t   npc;
      word_t   target;
      logic    taken;
   } btb_upd_t;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } sched_state_t;

endpackage

// File: rtl/btb_update_sched_fifo.sv
// DEPTH-entry FIFO of btb_upd_t with two push ports and one pop port.
// push1 is only meaningful together with push0 (it lands in the slot after).
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr_i           synchronous clear (wins over push/pop)
//   push0_i/_data_i first push of the cycle
//   push1_i/_data_i second push of the cycle
//   pop_i           drop the head entry (caller guarantees non-empty)
//   head_o          current head entry
//   count_o         occupancy, 0..DEPTH
module btb_update_sched_fifo
   import btb_update_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr_i,
   input  logic                     push0_i,
   input  btb_upd_t                 push0_data_i,
   input  logic                     push1_i,
   input  btb_upd_t                 push1_data_i,
   input  logic                     pop_i,
   output btb_upd_t                 head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_TWO = PTR_W'(2);

   btb_upd_t             mem_q [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [PTR_W:0]       count_q;

   always_ff @(posedge clk) begin
      if (!clr_i) begin
         if (push0_i) mem_q[wr_ptr_q] <= push0_data_i;
         if (push1_i) mem_q[wr_ptr_q + PTR_ONE] <= push1_data_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push0_i && push1_i) wr_ptr_q <= wr_ptr_q + PTR_TWO;
         else if (push0_i)       wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_i)              rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q <= count_q + {{PTR_W{1'b0}}, push0_i} + {{PTR_W{1'b0}}, push1_i}
                            - {{PTR_W{1'b0}}, pop_i};
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/btb_update_sched.sv
// Sequences every write into the BTB through its single write port.
// Exec branch updates and decode jump installs are queued (exec first) and
// drained one per cycle; a full invalidate sweep runs after reset and on flush.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   ex_upd_*_i               resolved branch from exec
//   de_upd_*_i               direct jump seen by decode
//   flush_req_i              pulse: invalidate the whole BTB
//   btb_hold_i               BTB write port blocked this cycle
//   upd_ready_o              updates accepted this cycle
//   wr_*_o                   BTB write port
//   busy_o                   sweeping or queue non-empty
//   drop_count_o             saturating count of updates lost to a full queue
//
// state    | meaning
// ST_INIT  | post-reset invalidate sweep, updates ignored
// ST_RUN   | accept updates, drain queue into BTB
// ST_FLUSH | flush invalidate sweep, updates ignored
module btb_update_sched
   import btb_update_sched_pkg::*;
#(
   parameter int ENTRIES = 4,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ex_upd_valid_i,
   input  logic [31:0]                  ex_upd_npc_i,
   input  logic [31:0]                  ex_upd_target_i,
   input  logic                         ex_upd_taken_i,
   input  logic                         de_upd_valid_i,
   input  logic [31:0]                  de_upd_npc_i,
   input  logic [31:0]                  de_upd_target_i,
   input  logic                         flush_req_i,
   input  logic                         btb_hold_i,
   output logic                         upd_ready_o,
   output logic                         wr_en_o,
   output logic [1:0]                   wr_op_o,
   output logic [$clog2(ENTRIES)-1:0]   wr_idx_o,
   output logic [31:0]                  wr_npc_o,
   output logic [31:0]                  wr_target_o,
   output logic                         wr_taken_o,
   output logic                         busy_o,
   output logic [CNT_W-1:0]             drop_count_o
);

   localparam int IDX_W  = $clog2(ENTRIES);
   localparam int OCC_W  = $clog2(DEPTH) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] FREE_ONE = OCC_W'(1);
   localparam logic [OCC_W-1:0] FREE_TWO = OCC_W'(2);

   sched_state_t       state_q, state_d;
   logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;
   logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CNT_W:0]     drop_sum;
   logic [1:0]         n_drop;

   logic               fifo_clr, fifo_pop, push0, push1;
   btb_upd_t           push0_data, push1_data, fifo_head, ex_req, de_req;
   logic [OCC_W-1:0]   fifo_count, free;
   logic               fifo_nempty, de_req_v;

   assign ex_req = '{BTB_BRANCH, ex_upd_npc_i, ex_upd_target_i, ex_upd_taken_i};
   assign de_req = '{BTB_JUMP,   de_upd_npc_i, de_upd_target_i, 1'b1};

   // A decode install aimed at the same entry as this cycle's exec update is
   // superseded by it; it is neither queued nor counted as a drop.
   assign de_req_v = de_upd_valid_i &&
                     !(ex_upd_valid_i &&
                       (ex_upd_npc_i[IDX_W+1:2] == de_upd_npc_i[IDX_W+1:2]));

   // Free space is taken at the start of the cycle: a same-cycle pop does not
   // make room for a same-cycle push.
   assign free        = OCC_FULL - fifo_count;
   assign fifo_nempty = (fifo_count != '0);

   btb_update_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (fifo_clr),
      .push0_i      (push0),
      .push0_data_i (push0_data),
      .push1_i      (push1),
      .push1_data_i (push1_data),
      .pop_i        (fifo_pop),
      .head_o       (fifo_head),
      .count_o      (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         sweep_idx_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         sweep_idx_q <= sweep_idx_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sweep_idx_d = sweep_idx_q;
      fifo_clr    = 1'b0;
      push0       = 1'b0;
      push1       = 1'b0;
      push0_data  = '0;
      push1_data  = '0;
      n_drop      = 2'd0;
      case (state_q)
         ST_INIT, ST_FLUSH: begin
            if (flush_req_i) begin
               sweep_idx_d = '0;
            end else if (!btb_hold_i) begin
               if (sweep_idx_q == LAST_IDX) begin
                  state_d     = ST_RUN;
                  sweep_idx_d = '0;
               end else begin
                  sweep_idx_d = sweep_idx_q + IDX_ONE;
               end
            end
         end
         ST_RUN: begin
            if (flush_req_i) begin
               fifo_clr = 1'b1;
               state_d  = ST_FLUSH;
            end else if (free >= FREE_TWO) begin
               if (ex_upd_valid_i) begin
                  push0      = 1'b1;
                  push0_data = ex_req;
                  push1      = de_req_v;
                  push1_data = de_req;
               end else begin
                  push0      = de_req_v;
                  push0_data = de_req;
               end
            end else if (free == FREE_ONE) begin
               if (ex_upd_valid_i) begin
                  push0      = 1'b1;
                  push0_data = ex_req;
                  n_drop     = {1'b0, de_req_v};
               end else begin
                  push0      = de_req_v;
                  push0_data = de_req;
               end
            end else begin
               n_drop = {1'b0, ex_upd_valid_i} + {1'b0, de_req_v};
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   assign drop_sum   = {1'b0, drop_cnt_q} + {{(CNT_W-1){1'b0}}, n_drop};
   assign drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

   // Write port is forced quiet while reset is asserted.
   always_comb begin
      wr_en_o     = 1'b0;
      wr_op_o     = BTB_INVAL;
      wr_idx_o    = '0;
      wr_npc_o    = '0;
      wr_target_o = '0;
      wr_taken_o  = 1'b0;
      fifo_pop    = 1'b0;
      if (rst_n) begin
         if (state_q == ST_RUN) begin
            if (fifo_nempty && !btb_hold_i) begin
               fifo_pop    = 1'b1;
               wr_en_o     = 1'b1;
               wr_op_o     = fifo_head.op;
               wr_idx_o    = fifo_head.npc[IDX_W+1:2];
               wr_npc_o    = fifo_head.npc;
               wr_target_o = fifo_head.target;
               wr_taken_o  = (fifo_head.op == BTB_JUMP) ? 1'b1 : fifo_head.taken;
            end
         end else begin
            wr_en_o  = 1'b1;
            wr_idx_o = sweep_idx_q;
         end
      end
   end

   assign upd_ready_o  = (state_q == ST_RUN);
   assign busy_o       = (state_q != ST_RUN) || fifo_nempty;
   assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_btb_update_sched.sv
module tb_btb_update_sched;

   localparam int DEPTH = 4;
   localparam logic [1:0] OP_INVAL  = 2'd0;
   localparam logic [1:0] OP_BRANCH = 2'd1;
   localparam logic [1:0] OP_JUMP   = 2'd2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_upd_valid, ex_upd_taken, de_upd_valid, flush_req, btb_hold;
   logic [31:0] ex_upd_npc, ex_upd_target, de_upd_npc, de_upd_target;
   logic        upd_ready, wr_en, wr_taken, busy;
   logic [1:0]  wr_op, wr_idx;
   logic [31:0] wr_npc, wr_target;
   logic [15:0] drop_count;

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  idx;
      logic [31:0] npc;
      logic [31:0] target;
      logic        taken;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_mis = 0;
   int   exp_drop = 0;

   btb_update_sched #(.ENTRIES(4), .DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ex_upd_valid_i  (ex_upd_valid),
      .ex_upd_npc_i    (ex_upd_npc),
      .ex_upd_target_i (ex_upd_target),
      .ex_upd_taken_i  (ex_upd_taken),
      .de_upd_valid_i  (de_upd_valid),
      .de_upd_npc_i    (de_upd_npc),
      .de_upd_target_i (de_upd_target),
      .flush_req_i     (flush_req),
      .btb_hold_i      (btb_hold),
      .upd_ready_o     (upd_ready),
      .wr_en_o         (wr_en),
      .wr_op_o         (wr_op),
      .wr_idx_o        (wr_idx),
      .wr_npc_o        (wr_npc),
      .wr_target_o     (wr_target),
      .wr_taken_o      (wr_taken),
      .busy_o          (busy),
      .drop_count_o    (drop_count)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk_inval(int idx);
      exp_t r;
      r.op = OP_INVAL; r.idx = 2'(idx); r.npc = '0; r.target = '0; r.taken = 1'b0;
      return r;
   endfunction

   function automatic exp_t mk_upd(logic [1:0] op, logic [31:0] npc, logic [31:0] tgt, logic tk);
      exp_t r;
      r.op = op; r.idx = npc[3:2]; r.npc = npc; r.target = tgt;
      r.taken = (op == OP_JUMP) ? 1'b1 : tk;
      return r;
   endfunction

   task automatic idle_inputs();
      ex_upd_valid = 0; ex_upd_npc = '0; ex_upd_target = '0; ex_upd_taken = 0;
      de_upd_valid = 0; de_upd_npc = '0; de_upd_target = '0;
      flush_req = 0; btb_hold = 0;
   endtask

   task automatic drive_ex(logic [31:0] npc, logic [31:0] tgt, logic tk);
      ex_upd_valid = 1; ex_upd_npc = npc; ex_upd_target = tgt; ex_upd_taken = tk;
   endtask

   task automatic drive_de(logic [31:0] npc, logic [31:0] tgt);
      de_upd_valid = 1; de_upd_npc = npc; de_upd_target = tgt;
   endtask

   // Each cycle: inputs change just after negedge, outputs sampled 2ns later.
   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      #2;
      n_cmp++; if (wr_en !== 1'b0) begin n_mis++; $display("FAIL reset_wr_en: got %b, required 0", wr_en); end
      n_cmp++; if (upd_ready !== 1'b0) begin n_mis++; $display("FAIL reset_upd_ready: got %b, required 0", upd_ready); end
      n_cmp++; if (drop_count !== 16'd0) begin n_mis++; $display("FAIL reset_drop_count: got %0d, required 0", drop_count); end
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 4; i++) sb.push_back(mk_inval(i));
      for (int c = 1; c <= 5; c++) begin
         #2;
         if (wr_en === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_mis++; $display("FAIL init_sweep unexpected write: got op=%0d idx=%0d, required no write", wr_op, wr_idx);
            end else begin
               e = sb.pop_front();
               if ({wr_op, wr_idx, wr_npc, wr_target, wr_taken} !== {e.op, e.idx, e.npc, e.target, e.taken}) begin
                  n_mis++; $display("FAIL init_sweep: got op=%0d idx=%0d npc=%h tgt=%h tk=%b, required op=%0d idx=%0d npc=%h tgt=%h tk=%b",
                     wr_op, wr_idx, wr_npc, wr_target, wr_taken, e.op, e.idx, e.npc, e.target, e.taken);
               end
            end
         end
         n_cmp++;
         if (upd_ready !== (c == 5)) begin
            n_mis++; $display("FAIL init_upd_ready cycle %0d: got %b, required %b", c, upd_ready, (c == 5));
         end
         @(negedge clk);
      end
      n_cmp++; if (sb.size() != 0) begin n_mis++; $display("FAIL init_sweep missing writes: got %0d outstanding, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_pair();
      idle_inputs();
      drive_ex(32'h104, 32'h200, 1'b1);
      drive_de(32'h10C, 32'h300);
      sb.push_back(mk_upd(OP_BRANCH, 32'h104, 32'h200, 1'b1));
      sb.push_back(mk_upd(OP_JUMP,   32'h10C, 32'h300, 1'b0));
      #2;
      n_cmp++; if (wr_en !== 1'b0) begin n_mis++; $display("FAIL pair_latency: got wr_en %b in accept cycle, required 0", wr_en); end
      @(negedge clk);
      idle_inputs();
      for (int c = 1; c <= 3; c++) begin
         #2;
         n_cmp++;
         if (wr_en !== (c < 3)) begin n_mis++; $display("FAIL pair_wr_en cycle %0d: got %b, required %b", c, wr_en, (c < 3)); end
         if (wr_en === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_mis++; $display("FAIL pair unexpected write: got op=%0d idx=%0d, required no write", wr_op, wr_idx);
            end else begin
               e = sb.pop_front();
               if ({wr_op, wr_idx, wr_npc, wr_target, wr_taken} !== {e.op, e.idx, e.npc, e.target, e.taken}) begin
                  n_mis++; $display("FAIL pair_write: got op=%0d idx=%0d npc=%h tgt=%h tk=%b, required op=%0d idx=%0d npc=%h tgt=%h tk=%b",
                     wr_op, wr_idx, wr_npc, wr_target, wr_taken, e.op, e.idx, e.npc, e.target, e.taken);
               end
            end
         end
         @(negedge clk);
      end
      #2;
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL pair_busy: got %b, required 0", busy); end
      n_cmp++; if (sb.size() != 0) begin n_mis++; $display("FAIL pair missing writes: got %0d outstanding, required 0", sb.size()); sb.delete(); end
      @(negedge clk);
   endtask

   task automatic test_same_idx();
      idle_inputs();
      drive_ex(32'h104, 32'h220, 1'b0);
      drive_de(32'h114, 32'h330);
      sb.push_back(mk_upd(OP_BRANCH, 32'h104, 32'h220, 1'b0));
      @(negedge clk);
      idle_inputs();
      for (int c = 1; c <= 3; c++) begin
         #2;
         if (wr_en === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_mis++; $display("FAIL same_idx unexpected write: got op=%0d idx=%0d npc=%h, required no write", wr_op, wr_idx, wr_npc);
            end else begin
               e = sb.pop_front();
               if ({wr_op, wr_idx, wr_npc, wr_target, wr_taken} !== {e.op, e.idx, e.npc, e.target, e.taken}) begin
                  n_mis++; $display("FAIL same_idx_write: got op=%0d idx=%0d npc=%h tgt=%h tk=%b, required op=%0d idx=%0d npc=%h tgt=%h tk=%b",
                     wr_op, wr_idx, wr_npc, wr_target, wr_taken, e.op, e.idx, e.npc, e.target, e.taken);
               end
            end
         end
         @(negedge clk);
      end
      #2;
      n_cmp++; if (drop_count !== 16'(exp_drop)) begin n_mis++; $display("FAIL same_idx_drop: got %0d, required %0d", drop_count, exp_drop); end
      n_cmp++; if (sb.size() != 0) begin n_mis++; $display("FAIL same_idx missing writes: got %0d outstanding, required 0", sb.size()); sb.delete(); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] ex_npc [3] = '{32'h100, 32'h104, 32'h108};
      logic [31:0] de_npc [3] = '{32'h108, 32'h10C, 32'h100};
      int occ = 0;
      for (int c = 0; c < 6; c++) begin
         idle_inputs();
         btb_hold = 1;
         if (c < 3) begin
            drive_ex(ex_npc[c], 32'h400 + 32'(c * 4), c[0]);
            drive_de(de_npc[c], 32'h500 + 32'(c * 4));
            if (occ <= DEPTH - 2) begin
               sb.push_back(mk_upd(OP_BRANCH, ex_npc[c], 32'h400 + 32'(c * 4), c[0]));
               sb.push_back(mk_upd(OP_JUMP, de_npc[c], 32'h500 + 32'(c * 4), 1'b0));
               occ += 2;
            end else if (occ == DEPTH - 1) begin
               sb.push_back(mk_upd(OP_BRANCH, ex_npc[c], 32'h400 + 32'(c * 4), c[0]));
               occ += 1; exp_drop += 1;
            end else begin
               exp_drop += 2;
            end
         end
         #2;
         n_cmp++; if (wr_en !== 1'b0) begin n_mis++; $display("FAIL hold_wr_en cycle %0d: got %b, required 0", c, wr_en); end
         @(negedge clk);
      end
      #2;
      n_cmp++; if (drop_count !== 16'(exp_drop)) begin n_mis++; $display("FAIL hold_drop_count: got %0d, required %0d", drop_count, exp_drop); end
      idle_inputs();
      for (int c = 0; c < 6; c++) begin
         #2;
         if (wr_en === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_mis++; $display("FAIL b2b unexpected write: got op=%0d idx=%0d npc=%h, required no write", wr_op, wr_idx, wr_npc);
            end else begin
               e = sb.pop_front();
               if ({wr_op, wr_idx, wr_npc, wr_target, wr_taken} !== {e.op, e.idx, e.npc, e.target, e.taken}) begin
                  n_mis++; $display("FAIL b2b_write: got op=%0d idx=%0d npc=%h tgt=%h tk=%b, required op=%0d idx=%0d npc=%h tgt=%h tk=%b",
                     wr_op, wr_idx, wr_npc, wr_target, wr_taken, e.op, e.idx, e.npc, e.target, e.taken);
               end
            end
         end
         @(negedge clk);
      end
      #2;
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL b2b_busy: got %b, required 0", busy); end
      n_cmp++; if (sb.size() != 0) begin n_mis++; $display("FAIL b2b missing writes: got %0d outstanding, required 0", sb.size()); sb.delete(); end
      @(negedge clk);
   endtask

   task automatic test_flush();
      idle_inputs();
      btb_hold = 1;
      drive_ex(32'h104, 32'h600, 1'b1);
      drive_de(32'h108, 32'h700);
      @(negedge clk);
      idle_inputs();
      btb_hold = 1;
      drive_ex(32'h100, 32'h604, 1'b0);
      @(negedge clk);
      idle_inputs();
      btb_hold = 1;
      flush_req = 1;
      drive_ex(32'h10C, 32'h608, 1'b1);
      #2;
      n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL flush_busy_queued: got %b, required 1", busy); end
      n_cmp++; if (wr_en !== 1'b0) begin n_mis++; $display("FAIL flush_cycle_wr_en: got %b, required 0", wr_en); end
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 4; i++) sb.push_back(mk_inval(i));
      for (int c = 1; c <= 6; c++) begin
         #2;
         if (wr_en === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_mis++; $display("FAIL flush unexpected write: got op=%0d idx=%0d npc=%h, required no write", wr_op, wr_idx, wr_npc);
            end else begin
               e = sb.pop_front();
               if ({wr_op, wr_idx, wr_npc, wr_target, wr_taken} !== {e.op, e.idx, e.npc, e.target, e.taken}) begin
                  n_mis++; $display("FAIL flush_write: got op=%0d idx=%0d npc=%h tgt=%h tk=%b, required op=%0d idx=%0d npc=%h tgt=%h tk=%b",
                     wr_op, wr_idx, wr_npc, wr_target, wr_taken, e.op, e.idx, e.npc, e.target, e.taken);
               end
            end
         end
         n_cmp++;
         if (upd_ready !== (c > 4)) begin n_mis++; $display("FAIL flush_upd_ready cycle %0d: got %b, required %b", c, upd_ready, (c > 4)); end
         @(negedge clk);
      end
      #2;
      n_cmp++; if (drop_count !== 16'(exp_drop)) begin n_mis++; $display("FAIL flush_drop_count: got %0d, required %0d", drop_count, exp_drop); end
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL flush_busy: got %b, required 0", busy); end
      n_cmp++; if (sb.size() != 0) begin n_mis++; $display("FAIL flush missing writes: got %0d outstanding, required 0", sb.size()); sb.delete(); end
      @(negedge clk);
   endtask

   task automatic test_init_hold();
      int seq [7] = '{0, 1, 2, 2, 2, 2, 3};
      idle_inputs();
      rst_n = 0;
      exp_drop = 0;
      #2;
      n_cmp++; if (drop_count !== 16'd0) begin n_mis++; $display("FAIL rereset_drop_count: got %0d, required 0", drop_count); end
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 7; i++) sb.push_back(mk_inval(seq[i]));
      for (int c = 1; c <= 8; c++) begin
         btb_hold = (c >= 3 && c <= 5);
         #2;
         if (wr_en === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_mis++; $display("FAIL init_hold unexpected write: got op=%0d idx=%0d, required no write", wr_op, wr_idx);
            end else begin
               e = sb.pop_front();
               if ({wr_op, wr_idx, wr_npc, wr_target, wr_taken} !== {e.op, e.idx, e.npc, e.target, e.taken}) begin
                  n_mis++; $display("FAIL init_hold_write cycle %0d: got op=%0d idx=%0d, required op=%0d idx=%0d",
                     c, wr_op, wr_idx, e.op, e.idx);
               end
            end
         end
         n_cmp++;
         if (upd_ready !== (c == 8)) begin n_mis++; $display("FAIL init_hold_upd_ready cycle %0d: got %b, required %b", c, upd_ready, (c == 8)); end
         @(negedge clk);
      end
      n_cmp++; if (sb.size() != 0) begin n_mis++; $display("FAIL init_hold missing writes: got %0d outstanding, required 0", sb.size()); sb.delete(); end
      btb_hold = 0;
   endtask

   initial begin
      rst_n = 1;
      idle_inputs();
      #1 rst_n = 0;
      @(negedge clk);
      test_reset();
      test_pair();
      test_same_idx();
      test_back_to_back();
      test_flush();
      test_init_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation exceeded 50000ns, required completion");
      $fatal(1, "timeout");
   end

endmodule
